// File: rtl/arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// starvation counter width, default geometry and a saturating increment helper.
package arb_pkg;

  localparam int AW_DEF       = 5;
  localparam int DW_DEF       = 32;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic {
    CPU_OWN  = 1'b0,
    DBG_WAIT = 1'b1
  } arb_state_e;

  function automatic logic [STARVE_CNT_W-1:0] sat_inc(
    input logic [STARVE_CNT_W-1:0] val,
    input logic [STARVE_CNT_W-1:0] lim
  );
    return (val >= lim) ? lim : val + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Data memory storage: 2^AW words, synchronous write, combinational read,
// power-up image 0xA00000AA..0x90000099 in words 0..9 and zero elsewhere.
module dmem_bank
  import arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int WORDS = 1 << AW;

  // NOTE: the array has no reset; contents survive rst and start from the image.
  logic [DW-1:0] mem_q [WORDS] = '{
    0: DW'(32'hA00000AA),
    1: DW'(32'h10000011),
    2: DW'(32'h20000022),
    3: DW'(32'h30000033),
    4: DW'(32'h40000044),
    5: DW'(32'h50000055),
    6: DW'(32'h60000066),
    7: DW'(32'h70000077),
    8: DW'(32'h80000088),
    9: DW'(32'h90000099),
    default: '0
  };

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory port between the MEM stage (priority) and a debug port,
// forcing a one-cycle CPU stall once debug has waited STARVE_MAX cycles.
// Optional build macro ARB_PERF_EN adds a saturating stall-cycle counter output.
module dmem_arbiter
  import arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [15:0]   perf_stall_cnt
`endif
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  arb_state_e              state_q, state_d;
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                    dbg_rvalid_q, dbg_rvalid_d;
  logic [DW-1:0]           dbg_rdata_q, dbg_rdata_d;

  logic                    force_gnt;
  logic                    dbg_rd;
  logic [AW-1:0]           cpu_word;
  logic [AW-1:0]           mem_addr;
  logic                    mem_we;
  logic [DW-1:0]           mem_wdata;
  logic [DW-1:0]           mem_rdata;
  logic                    unused_addr_bits;

  // Byte offset and bits above the word index are don't-care; addresses wrap.
  assign cpu_word         = cpu_addr[AW+1:2];
  assign unused_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};

  assign force_gnt = dbg_req & (starve_cnt_q == STARVE_LIM);
  assign dbg_gnt   = dbg_req & (~cpu_req | force_gnt);
  assign cpu_stall = cpu_req & dbg_gnt;

  // NOTE: combinational processes assign every output a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = '0;
    case (state_q)
      CPU_OWN:  if (dbg_req & cpu_req & ~force_gnt) state_d = DBG_WAIT;
      DBG_WAIT: if (dbg_gnt | ~dbg_req)             state_d = CPU_OWN;
      default:  state_d = CPU_OWN;
    endcase
    // Counter reads 1 on the first waiting cycle so the grant lands after STARVE_MAX denials.
    if (state_d == DBG_WAIT) begin
      starve_cnt_d = sat_inc(starve_cnt_q, STARVE_LIM);
    end
  end

  // A granted debug access always owns the port; otherwise the CPU does.
  always_comb begin
    mem_addr  = dbg_gnt ? dbg_addr  : cpu_word;
    mem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
    mem_we    = dbg_gnt ? dbg_we    : (cpu_req & cpu_we);
  end

  dmem_bank #(
    .AW (AW),
    .DW (DW)
  ) u_bank (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign cpu_rdata = (cpu_req & ~cpu_we & ~cpu_stall) ? mem_rdata : '0;

  always_comb begin
    dbg_rd       = dbg_gnt & ~dbg_we;
    dbg_rvalid_d = dbg_rd;
    dbg_rdata_d  = dbg_rd ? mem_rdata : dbg_rdata_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CPU_OWN;
      starve_cnt_q <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;

`ifdef ARB_PERF_EN
  logic [15:0] perf_stall_cnt_q, perf_stall_cnt_d;

  always_comb begin
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (cpu_stall && (perf_stall_cnt_q != 16'hFFFF)) begin
      perf_stall_cnt_d = perf_stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_stall_cnt_q <= '0;
    else     perf_stall_cnt_q <= perf_stall_cnt_d;
  end

  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then random traffic,
// all compared against a word-array / denial-run model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int AW         = 5;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 4;
  localparam int WORDS      = 1 << AW;

  logic          clk;
  logic          rst;
  logic          cpu_req;
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
`ifdef ARB_PERF_EN
  logic [15:0]   perf_stall_cnt;
`endif

  dmem_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_stall      (cpu_stall),
    .dbg_req        (dbg_req),
    .dbg_we         (dbg_we),
    .dbg_addr       (dbg_addr),
    .dbg_wdata      (dbg_wdata),
    .dbg_gnt        (dbg_gnt),
    .dbg_rvalid     (dbg_rvalid),
    .dbg_rdata      (dbg_rdata)
`ifdef ARB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int errors = 0;
  int checks = 0;

  // Reference model: memory contents, consecutive denied-debug cycles, and
  // the registered debug read outputs expected in the current cycle.
  logic [31:0] m_mem [WORDS];
  int          denied_run;
  logic        exp_rvalid;
  logic [31:0] exp_rdata;
  int          exp_perf;
  logic        e_gnt;
  logic        e_stall;
  int          e_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < WORDS; i++) begin
      int k;
      k = (i == 0) ? 10 : i;
      m_mem[i] = (i < 10) ? ((32'(k) << 28) | (32'(k) * 32'h11)) : 32'h0;
    end
    denied_run = 0;
    exp_rvalid = 1'b0;
    exp_rdata  = 32'h0;
    exp_perf   = 0;
    e_gnt      = 1'b0;
    e_stall    = 1'b0;
  endtask

  task automatic model_reset();
    denied_run = 0;
    exp_rvalid = 1'b0;
    exp_rdata  = 32'h0;
    exp_perf   = 0;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [AW-1:0] da, input logic [31:0] dd);
    cpu_req   = cr;
    cpu_we    = cw;
    cpu_addr  = ca;
    cpu_wdata = cd;
    dbg_req   = dr;
    dbg_we    = dw;
    dbg_addr  = da;
    dbg_wdata = dd;
  endtask

  // Predict this cycle's outputs from the current inputs, then sample mid-cycle.
  task automatic eval_cycle();
    logic        force_now;
    logic [31:0] e_cpu;
    e_word    = int'(cpu_addr / 32'd4) % WORDS;
    force_now = dbg_req && (denied_run == STARVE_MAX);
    e_gnt     = dbg_req && (!cpu_req || force_now);
    e_stall   = cpu_req && e_gnt;
    e_cpu     = (cpu_req && !cpu_we && !e_stall) ? m_mem[e_word] : 32'h0;
    @(negedge clk);
    check("dbg_gnt",    32'(dbg_gnt),    32'(e_gnt));
    check("cpu_stall",  32'(cpu_stall),  32'(e_stall));
    check("cpu_rdata",  cpu_rdata,       e_cpu);
    check("dbg_rvalid", 32'(dbg_rvalid), 32'(exp_rvalid));
    check("dbg_rdata",  dbg_rdata,       exp_rdata);
`ifdef ARB_PERF_EN
    check("perf_cnt",   32'(perf_stall_cnt), 32'(exp_perf));
`endif
  endtask

  // Apply the clock edge to the model, then leave inputs free to change.
  task automatic commit_cycle();
    @(posedge clk);
    exp_rvalid = e_gnt && !dbg_we;
    if (e_gnt && !dbg_we) exp_rdata = m_mem[dbg_addr];
    if (e_gnt && dbg_we)                       m_mem[dbg_addr] = dbg_wdata;
    else if (cpu_req && cpu_we && !e_stall)    m_mem[e_word]   = cpu_wdata;
    denied_run = (dbg_req && !e_gnt) ? denied_run + 1 : 0;
    if (e_stall && exp_perf < 16'hFFFF) exp_perf++;
    #1;
  endtask

  task automatic cyc();
    eval_cycle();
    commit_cycle();
  endtask

  // CPU busy and debug waiting: grant and stall must appear on the 5th cycle only.
  task automatic starve_burst(input string tag);
    drive(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 5'd7, 32'h0);
    for (int i = 0; i <= STARVE_MAX; i++) begin
      eval_cycle();
      check({tag, "_gnt"},   32'(dbg_gnt),   (i == STARVE_MAX) ? 32'd1 : 32'd0);
      check({tag, "_stall"}, 32'(cpu_stall), (i == STARVE_MAX) ? 32'd1 : 32'd0);
      commit_cycle();
    end
    dbg_req = 1'b0;
    eval_cycle();
    check({tag, "_no_stall_after"}, 32'(cpu_stall), 32'd0);
    commit_cycle();
  endtask

  initial begin
    model_init();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0, 32'h0);

    // Reset state
    #12;
    check("rst_rvalid", 32'(dbg_rvalid), 32'd0);
    check("rst_rdata",  dbg_rdata,       32'h0);
    check("rst_stall",  32'(cpu_stall),  32'd0);
    check("rst_gnt",    32'(dbg_gnt),    32'd0);
`ifdef ARB_PERF_EN
    check("rst_perf",   32'(perf_stall_cnt), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: zero-latency CPU load from the initial image
    drive(1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 1'b0, '0, 32'h0);
    eval_cycle();
    check("t1_rdata", cpu_rdata, 32'h2000_0022);
    check("t1_stall", 32'(cpu_stall), 32'd0);
    commit_cycle();

    // 2: debug write then read-back while CPU idle
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF);
    eval_cycle();
    check("t2_wr_gnt", 32'(dbg_gnt), 32'd1);
    commit_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd3, 32'h0);
    eval_cycle();
    check("t2_rd_gnt", 32'(dbg_gnt), 32'd1);
    commit_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
    eval_cycle();
    check("t2_rvalid", 32'(dbg_rvalid), 32'd1);
    check("t2_rdata",  dbg_rdata, 32'hDEAD_BEEF);
    commit_cycle();
    eval_cycle();
    check("t2_rvalid_drop", 32'(dbg_rvalid), 32'd0);
    commit_cycle();

    // 3: starvation forces exactly one CPU stall
    starve_burst("t3");

    // 4: CPU store then load; debug sees the same word
    drive(1'b1, 1'b1, 32'h0000_0014, 32'h1234_5678, 1'b0, 1'b0, '0, 32'h0);
    cyc();
    drive(1'b1, 1'b0, 32'h0000_0014, 32'h0, 1'b0, 1'b0, '0, 32'h0);
    eval_cycle();
    check("t4_cpu_rdata", cpu_rdata, 32'h1234_5678);
    commit_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd5, 32'h0);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
    eval_cycle();
    check("t4_dbg_rdata", dbg_rdata, 32'h1234_5678);
    commit_cycle();

    // 5: async reset in the cycle after a debug read grant drops the read
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd3, 32'h0);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    eval_cycle();
    check("t5_rvalid", 32'(dbg_rvalid), 32'd0);
    commit_cycle();
    drive(1'b1, 1'b0, 32'hFFFF_FF8C, 32'h0, 1'b0, 1'b0, '0, 32'h0);
    eval_cycle();
    check("t5_mem_w3_wrap", cpu_rdata, 32'hDEAD_BEEF);
    commit_cycle();
    drive(1'b1, 1'b0, 32'h0000_0016, 32'h0, 1'b0, 1'b0, '0, 32'h0);
    eval_cycle();
    check("t5_mem_w5", cpu_rdata, 32'h1234_5678);
    commit_cycle();

    // 6: three forced stalls after reset
    for (int r = 0; r < 3; r++) starve_burst("t6");
`ifdef ARB_PERF_EN
    check("t6_perf", 32'(perf_stall_cnt), 32'd3);
`endif

    // Random traffic; a waiting debug request and a stalled CPU hold their inputs.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
    cyc();
    for (int i = 0; i < 600; i++) begin
      if (!(cpu_req && e_stall)) begin
        cpu_req   = ($urandom_range(3) != 0);
        cpu_we    = $urandom_range(1) == 1;
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
      end
      if (!(dbg_req && !e_gnt)) begin
        dbg_req   = $urandom_range(1) == 1;
        dbg_we    = $urandom_range(2) == 0;
        dbg_addr  = AW'($urandom);
        dbg_wdata = $urandom;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
